// File: rtl/vscpu_param_core_if.sv
// Single-port memory bus between the VerySimpleCPU core (master) and program/data RAM (slave).
// req is held with addr/we/wdata stable until ack; ack may arrive in the same cycle req rises.
interface vscpu_param_core_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/vscpu_param_core.sv
// Multi-cycle VerySimpleCPU core: one access per state, stalls on mem_ack, zero-wait latency = accesses + 1 clk.
// Define VSCPU_MUL_EN to implement MUL/MULi; otherwise op111 is a fetch-only NOP.
module vscpu_param_core #(
  parameter int              ADDR_W   = 14,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  vscpu_param_core_if.master  mem,
  output logic [ADDR_W-1:0]   pc,
  output logic                instr_done,
  output logic                halted
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_RD1   = 3'd2;  // read M[A]
  localparam logic [2:0] S_RD2   = 3'd3;  // read M[B]
  localparam logic [2:0] S_RD3   = 3'd4;  // read M[M[B]]
  localparam logic [2:0] S_WR    = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;

`ifdef VSCPU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic [2:0]        state, nxt;
  logic [31:0]       iw;
  logic [DATA_W-1:0] opa, opb;
  logic [2:0]        op, f_op;
  logic              imm, f_imm;
  logic [ADDR_W-1:0] a_addr, b_addr, wr_addr, pc_inc, new_pc;
  logic [DATA_W-1:0] bimm, src, alu, wr_data;
  logic              retire;

  assign op     = iw[31:29];
  assign imm    = iw[28];
  assign f_op   = mem.mem_rdata[31:29];
  assign f_imm  = mem.mem_rdata[28];
  assign a_addr = iw[14 +: ADDR_W];
  assign b_addr = iw[0 +: ADDR_W];
  assign bimm   = {{(DATA_W-14){1'b0}}, iw[13:0]};
  assign pc_inc = pc + ADDR_W'(1);
  assign src    = imm ? bimm : opb;
  // CPIi writes through the pointer read from M[A]
  assign wr_addr = (op == 3'b101 && imm) ? opa[ADDR_W-1:0] : a_addr;

  always_comb begin
    alu = opa + src;
    case (op)
      3'b001:  alu = ~(opa & src);
      3'b010:  alu = (src < DATA_W'(32)) ? (opa >> src) : (opa << (src - DATA_W'(32)));
      3'b011:  alu = {{(DATA_W-1){1'b0}}, (opa < src)};
`ifdef VSCPU_MUL_EN
      3'b111:  alu = opa * src;
`endif
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      3'b100:  wr_data = imm ? bimm : opb;
      3'b101:  wr_data = opb;
      default: wr_data = alu;
    endcase
  end

  always_comb begin
    nxt    = state;
    retire = 1'b0;
    new_pc = pc_inc;
    case (state)
      S_IDLE:  if (run && !halted) nxt = S_FETCH;
      S_FETCH: if (mem.mem_ack) begin
        if (f_op == 3'b111 && !MUL_EN)                  retire = 1'b1;
        else if (f_op == 3'b100 && f_imm)               nxt = S_WR;
        else if (f_op == 3'b100 || (f_op == 3'b101 && !f_imm) ||
                 (f_op == 3'b110 && !f_imm))            nxt = S_RD2;
        else                                            nxt = S_RD1;
      end
      S_RD1: if (mem.mem_ack) begin
        if (op == 3'b110) begin
          retire = 1'b1;
          if (imm)            new_pc = mem.mem_rdata[ADDR_W-1:0] + b_addr;
          else if (opb == '0) new_pc = mem.mem_rdata[ADDR_W-1:0];
        end
        else if (imm && op != 3'b101) nxt = S_WR;
        else                          nxt = S_RD2;
      end
      S_RD2: if (mem.mem_ack) begin
        if (op == 3'b110)                nxt = S_RD1;
        else if (op == 3'b101 && !imm)   nxt = S_RD3;
        else                             nxt = S_WR;
      end
      S_RD3:   if (mem.mem_ack) nxt = S_WR;
      S_WR:    if (mem.mem_ack) retire = 1'b1;
      default: ;
    endcase
    // a retire that leaves PC unchanged is a self-jump
    if (retire) nxt = (new_pc == pc) ? S_HALT : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      iw         <= '0;
      opa        <= '0;
      opb        <= '0;
      instr_done <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= nxt;
      instr_done <= retire;
      if (retire) begin
        pc     <= new_pc;
        halted <= (new_pc == pc);
      end
      if (mem.mem_ack) begin
        case (state)
          S_FETCH:      iw  <= mem.mem_rdata[31:0];
          S_RD1:        opa <= mem.mem_rdata;
          S_RD2, S_RD3: opb <= mem.mem_rdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (state)
      S_FETCH: begin mem.mem_req = 1'b1; mem.mem_addr = pc;                end
      S_RD1:   begin mem.mem_req = 1'b1; mem.mem_addr = a_addr;            end
      S_RD2:   begin mem.mem_req = 1'b1; mem.mem_addr = b_addr;            end
      S_RD3:   begin mem.mem_req = 1'b1; mem.mem_addr = opb[ADDR_W-1:0];   end
      S_WR: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = wr_addr;
        mem.mem_wdata = wr_data;
      end
      default: ;
    endcase
  end

endmodule
